polar_result_serializer: RTL and testbench
==========================================

// Module: polar_result_serializer
// PURPOSE
//  Downstream stage of the rectangular-to-cylindrical converter. Accepts (r, theta) result pairs
//  with a valid/ready handshake and buffers them in a small FIFO. Streams each pair out as
//  consecutive bytes on one 8-bit bus with its own valid/ready handshake.
//  Decouples converter throughput from a byte-wide pin-limited consumer.
// PARAMETERS
//  DATA_W  8  width of r, theta and out_data
//  DEPTH   4  FIFO entries (r,theta pairs); power of two, >=2
// PORTS
//  clk        in   1                     single clock, all state on rising edge
//  rst        in   1                     asynchronous, active-high reset
//  in_valid   in   1                     r_in/theta_in hold a valid pair
//  in_ready   out  1                     FIFO can accept a pair this cycle
//  r_in       in   DATA_W                magnitude from converter
//  theta_in   in   DATA_W                angle from converter
//  out_valid  out  1                     out_data holds a valid byte
//  out_ready  in   1                     consumer accepts out_data this cycle
//  out_data   out  DATA_W                serialized byte
//  out_first  out  1                     high while out_data is first byte (r) of a frame
//  fifo_level out  $clog2(DEPTH)+1       stored pairs, including the one being sent
// BEHAVIOUR
//  Reset (async assert, sync-safe release): FIFO empty, pointers 0, FSM=IDLE, out_valid=0,
//    out_data=0, out_first=0, fifo_level=0, in_ready=1. Any partial frame is discarded.
//  Push: in_valid & in_ready at edge -> pair written at wr_ptr, wr_ptr+1 (wraps mod DEPTH).
//  in_ready = (fifo_level != DEPTH), combinational from registered level only. A pop in the
//    same cycle does NOT allow a push when full.
//  Pop: occurs on the edge completing the last byte of a frame; rd_ptr+1 (wraps mod DEPTH).
//  Simultaneous push and pop: fifo_level unchanged, both pointers advance.
//  Push is ignored (no state change) when in_ready=0. in_valid is not required to stay high.
//  FSM states: IDLE, SEND_R, SEND_T (+ SEND_C with CHECKSUM).
//    IDLE:   level>0 -> SEND_R next edge. Else stay.
//    SEND_R: out_valid=1, out_first=1, out_data=head.r. out_ready -> SEND_T.
//    SEND_T: out_valid=1, out_first=0, out_data=head.theta. out_ready -> pop, then:
//            level after pop >0 -> SEND_R (back-to-back, no bubble). Else IDLE.
//    No out_ready: state and out_data hold, so the byte stays stable until accepted.
//  out_* driven from FSM state and FIFO head. Head is registered storage, so no combinational
//    path exists from in_* to out_*.
//  Latency: pair pushed into empty FIFO at edge N -> out_valid=1 after edge N+1. Frame takes
//    2 accepted cycles (3 with CHECKSUM). Sustained rate 1 pair / 2 cycles at out_ready=1.
//  fifo_level counts from push edge until pop edge. Range 0..DEPTH, never wraps.
// CONFIGURATION
//  CHECKSUM_EN defined: SEND_T with out_ready -> SEND_C.
//    SEND_C: out_valid=1, out_first=0, out_data = head.r ^ head.theta. out_ready -> pop.
//    Pop moves to SEND_R if more data remains, otherwise to IDLE. Frame = 3 bytes.
//  CHECKSUM_EN undefined: SEND_C absent. Frame = 2 bytes exactly as above.
// TESTING
//  1. Reset, push (r=22, theta=63), out_ready=1 -> bytes 22 (first=1), 63 (first=0); level 1->0.
//     With CHECKSUM_EN a third byte 41 follows.
//  2. out_ready=0, push 4 pairs (1,2),(3,4),(5,6),(7,8) -> level=4, in_ready=0.
//     5th push (9,10) ignored. Release out_ready -> bytes 1..8 in order.
//  3. FIFO full; in the cycle the pop of (1,2) occurs, in_valid=1 with (9,10) -> not accepted.
//     Next cycle it is accepted; level stays 4.
//  4. Continuous push every 2 cycles with out_ready=1 -> out_valid stays high.
//     Back-to-back frames show no idle cycle; pointers wrap past DEPTH with no loss.
//  5. Stall mid-frame: after r byte accepted, out_ready=0 for 5 cycles.
//     out_data holds theta and out_valid stays 1 throughout.
//  6. Assert rst while in SEND_T with level=3 -> outputs 0, level=0 and in_ready=1 immediately.
//     After release, no stale byte is emitted.

Source files
------------

// File: rtl/polar_result_serializer.sv
// Buffers (r, theta) result pairs in a small FIFO and streams each pair out as bytes on one bus.
// Optional CHECKSUM_EN adds a third byte per frame: r ^ theta.
module polar_result_serializer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        r_in,
    input  logic [DATA_W-1:0]        theta_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_first,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef struct packed {
        logic [DATA_W-1:0] r;
        logic [DATA_W-1:0] theta;
    } pair_t;

`ifdef CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, SEND_R, SEND_T, SEND_C} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND_R, SEND_T} state_t;
`endif

    pair_t         mem [DEPTH];
    pair_t         head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level, level_nxt;
    logic          push, pop;
    state_t        state, state_nxt;

    assign head       = mem[rd_ptr];
    assign fifo_level = level;
    // Ready depends only on the registered level; a same-cycle pop never frees a slot.
    assign in_ready   = (level != LW'(DEPTH));
    assign push       = in_valid & in_ready;
`ifdef CHECKSUM_EN
    assign pop        = out_ready & (state == SEND_C);
`else
    assign pop        = out_ready & (state == SEND_T);
`endif
    assign level_nxt  = level + LW'(push) - LW'(pop);

    // Storage needs no reset: head is only observed in SEND_* states, which imply level > 0.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{r: r_in, theta: theta_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            level <= level_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (level != '0) state_nxt = SEND_R;
            SEND_R: if (out_ready)   state_nxt = SEND_T;
`ifdef CHECKSUM_EN
            SEND_T: if (out_ready)   state_nxt = SEND_C;
            SEND_C: if (out_ready)   state_nxt = (level_nxt != '0) ? SEND_R : IDLE;
`else
            // A push landing on the pop edge keeps the stream gapless.
            SEND_T: if (out_ready)   state_nxt = (level_nxt != '0) ? SEND_R : IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_first = 1'b0;
        out_data  = '0;
        case (state)
            SEND_R: begin
                out_valid = 1'b1;
                out_first = 1'b1;
                out_data  = head.r;
            end
            SEND_T: begin
                out_valid = 1'b1;
                out_data  = head.theta;
            end
`ifdef CHECKSUM_EN
            SEND_C: begin
                out_valid = 1'b1;
                out_data  = head.r ^ head.theta;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_polar_result_serializer.sv
// Directed bench for polar_result_serializer; expected bytes are hand-derived constants.
// Compile with CHECKSUM_EN defined to exercise the three-byte frame.
module tb_polar_result_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready;
    logic [7:0] r_in, theta_in;
    logic       out_valid, out_ready, out_first;
    logic [7:0] out_data;
    logic [2:0] fifo_level;

    int checks = 0;
    int errors = 0;

`ifdef CHECKSUM_EN
    localparam int F = 3;
`else
    localparam int F = 2;
`endif

    polar_result_serializer #(.DATA_W(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .r_in(r_in), .theta_in(theta_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_first(out_first),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_frame(input logic [7:0] r, input logic [7:0] t);
        chk("frame_r", {24'd0, out_data}, {24'd0, r});
        chk("frame_first", {31'd0, out_first}, 32'd1);
        tick();
        chk("frame_t", {24'd0, out_data}, {24'd0, t});
        chk("frame_t_first", {31'd0, out_first}, 32'd0);
        tick();
`ifdef CHECKSUM_EN
        chk("frame_c", {24'd0, out_data}, {24'd0, r ^ t});
        tick();
`endif
    endtask

    // Byte j of the continuous stream in the throughput step: pair k = (16k+1, 16k+2).
    function automatic logic [7:0] stream_byte(input int j);
        logic [7:0] r, t;
        r = 8'((j / F) * 16 + 1);
        t = 8'((j / F) * 16 + 2);
        case (j % F)
            0:       return r;
            1:       return t;
            default: return r ^ t;
        endcase
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; r_in = '0; theta_in = '0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_first", {31'd0, out_first}, 32'd0);
        chk("rst_level", {29'd0, fifo_level}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        tick();

        // Single pair, consumer always ready
        out_ready = 1'b1;
        in_valid = 1'b1; r_in = 8'd22; theta_in = 8'd63;
        tick();
        in_valid = 1'b0;
        chk("t1_level1", {29'd0, fifo_level}, 32'd1);
        chk("t1_idle_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        expect_frame(8'd22, 8'd63);
        chk("t1_done_valid", {31'd0, out_valid}, 32'd0);
        chk("t1_level0", {29'd0, fifo_level}, 32'd0);

        // Fill while stalled, then overflow attempt
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; r_in = 8'(2 * i + 1); theta_in = 8'(2 * i + 2);
            tick();
        end
        in_valid = 1'b0;
        chk("t2_level_full", {29'd0, fifo_level}, 32'd4);
        chk("t2_in_ready0", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1; r_in = 8'd9; theta_in = 8'd10;
        tick();
        in_valid = 1'b0;
        chk("t2_push_ignored", {29'd0, fifo_level}, 32'd4);
        chk("t2_head_r", {24'd0, out_data}, 32'd1);
        chk("t2_head_first", {31'd0, out_first}, 32'd1);

        // Drain; push offered on the pop edge must be refused
        out_ready = 1'b1;
        tick();
        chk("t3_theta", {24'd0, out_data}, 32'd2);
`ifdef CHECKSUM_EN
        tick();
        chk("t3_cks", {24'd0, out_data}, 32'd3);
`endif
        in_valid = 1'b1; r_in = 8'd9; theta_in = 8'd10;
        tick();
        chk("t3_pop_no_push", {29'd0, fifo_level}, 32'd3);
        chk("t3_in_ready1", {31'd0, in_ready}, 32'd1);
        chk("t3_next_r", {24'd0, out_data}, 32'd3);
        tick();
        in_valid = 1'b0;
        chk("t3_push_late", {29'd0, fifo_level}, 32'd4);
        chk("t3_theta4", {24'd0, out_data}, 32'd4);
        tick();
`ifdef CHECKSUM_EN
        chk("t3_cks7", {24'd0, out_data}, 32'd7);
        tick();
`endif
        expect_frame(8'd5, 8'd6);
        expect_frame(8'd7, 8'd8);
        expect_frame(8'd9, 8'd10);
        chk("t3_empty_valid", {31'd0, out_valid}, 32'd0);
        chk("t3_empty_level", {29'd0, fifo_level}, 32'd0);

        // Sustained throughput, pointers wrap past DEPTH
        for (int c = 0; c < 6 * F; c++) begin
            if (c % F == 0) begin
                in_valid = 1'b1; r_in = 8'((c / F) * 16 + 1); theta_in = 8'((c / F) * 16 + 2);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (c >= 1) begin
                chk("t4_valid", {31'd0, out_valid}, 32'd1);
                chk("t4_data", {24'd0, out_data}, {24'd0, stream_byte(c - 1)});
            end
        end
        in_valid = 1'b0;
        tick();
        chk("t4_last", {24'd0, out_data}, {24'd0, stream_byte(6 * F - 1)});
        tick();
        chk("t4_idle", {31'd0, out_valid}, 32'd0);

        // Stall mid-frame
        in_valid = 1'b1; r_in = 8'hA5; theta_in = 8'h5A;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t5_r", {24'd0, out_data}, 32'hA5);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t5_hold_data", {24'd0, out_data}, 32'h5A);
        end
        out_ready = 1'b1;
        tick();
`ifdef CHECKSUM_EN
        chk("t5_cks", {24'd0, out_data}, 32'hFF);
        tick();
`endif
        chk("t5_done", {31'd0, out_valid}, 32'd0);

        // Reset mid-frame with three pairs stored
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; r_in = 8'(11 + 2 * i); theta_in = 8'(12 + 2 * i);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t6_in_send_t", {24'd0, out_data}, 32'd12);
        chk("t6_level3", {29'd0, fifo_level}, 32'd3);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_data", {24'd0, out_data}, 32'd0);
        chk("t6_rst_level", {29'd0, fifo_level}, 32'd0);
        chk("t6_rst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_no_stale", {31'd0, out_valid}, 32'd0);
        end
        chk("t6_level_after", {29'd0, fifo_level}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
